// File: rtl/seg7_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux_if
//  Description : Display-content bus between the producer (top-level FSM /
//                datapath) and the seven-segment scan driver, plus the pin and
//                status outputs returned by the driver.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int PWM_BITS   = 3
);
    logic [4*NUM_DIGITS-1:0] digit_data;
    logic [7*NUM_DIGITS-1:0] raw_seg;
    logic [NUM_DIGITS-1:0]   raw_mode;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blink;
    logic [PWM_BITS-1:0]     brightness;
    logic                    load;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   an_n;
    logic                    update_pending;
    logic                    frame_tick;

    // Producer side: supplies display content, observes pins and status.
    modport master (
        output digit_data, raw_seg, raw_mode, blank, dp, blink, brightness, load,
        input  seg_n, dp_n, an_n, update_pending, frame_tick
    );

    // Driver side.
    modport slave (
        input  digit_data, raw_seg, raw_mode, blank, dp, blink, brightness, load,
        output seg_n, dp_n, an_n, update_pending, frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_mux
//  Description : N-digit time-multiplexed seven-segment driver. Hex or raw
//                digits, per-digit blank/dp/blink, PWM brightness, and a
//                double-buffered display image swapped only at frame wrap.
//                Optional macro LEADING_ZERO_SUPPRESS_EN blanks leading hex
//                zeros (rightmost digit always shown).
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 16384,
    parameter int PWM_BITS    = 3,
    parameter int BLINK_BITS  = 5
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    seg7_scan_mux_if.slave  disp
);
    localparam int c_CNT_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] data;
        logic [7*NUM_DIGITS-1:0] raw_seg;
        logic [NUM_DIGITS-1:0]   raw_mode;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blink;
        logic [PWM_BITS-1:0]     bright;
    } disp_buf_t;

    // Hex nibble to abc_defg pattern, 1 = lit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;
            4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
            4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;
            4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
            4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;
            4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
        endcase
    endfunction

    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    disp_buf_t             r_act;
    disp_buf_t             r_pend;
    logic                  r_upd;
    logic                  r_tick;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;
    logic [NUM_DIGITS-1:0] r_an_n;

    disp_buf_t             w_in;
    logic                  w_cnt_last;
    logic                  w_wrap;
    logic [3:0]            w_nib;
    logic [6:0]            w_raw_pat;
    logic                  w_raw;
    logic                  w_blank;
    logic                  w_dpv;
    logic                  w_blinkv;
    logic                  w_lz;
    logic [NUM_DIGITS-1:0] w_lz_vec;
    logic                  w_off;
    logic [6:0]            w_pat;
    logic                  w_an_on;
    logic [NUM_DIGITS-1:0] w_an_n;

    assign w_cnt_last = (r_cnt == c_CNT_LAST);
    assign w_wrap     = w_cnt_last && (r_idx == c_IDX_LAST);

    // Gather the live display inputs into one capture word.
    always_comb begin
        w_in          = '0;
        w_in.data     = disp.digit_data;
        w_in.raw_seg  = disp.raw_seg;
        w_in.raw_mode = disp.raw_mode;
        w_in.blank    = disp.blank;
        w_in.dp       = disp.dp;
        w_in.blink    = disp.blink;
        w_in.bright   = disp.brightness;
    end

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic w_lz_run;
    // Scan left to right; suppression holds until a raw or visible non-zero digit.
    always_comb begin
        w_lz_vec = '0;
        w_lz_run = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_act.raw_mode[i] || (!r_act.blank[i] && (r_act.data[4*i +: 4] != 4'd0)))
                w_lz_run = 1'b0;
            w_lz_vec[i] = w_lz_run && !r_act.raw_mode[i] &&
                          (r_act.data[4*i +: 4] == 4'd0) && (i != NUM_DIGITS - 1);
        end
    end
`else
    assign w_lz_vec = '0;
`endif

    // Select the active-buffer fields of the digit currently being scanned.
    always_comb begin
        w_nib     = '0;
        w_raw_pat = '0;
        w_raw     = 1'b0;
        w_blank   = 1'b0;
        w_dpv     = 1'b0;
        w_blinkv  = 1'b0;
        w_lz      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_nib     = r_act.data[4*i +: 4];
                w_raw_pat = r_act.raw_seg[7*i +: 7];
                w_raw     = r_act.raw_mode[i];
                w_blank   = r_act.blank[i];
                w_dpv     = r_act.dp[i];
                w_blinkv  = r_act.blink[i];
                w_lz      = w_lz_vec[i];
            end
        end
    end

    assign w_off   = w_blank || (w_blinkv && r_blink_cnt[BLINK_BITS-1]) || w_lz;
    assign w_pat   = w_raw ? w_raw_pat : hex7(w_nib);
    // Slot cycle 0 is dead time; the top count bits form the PWM ramp.
    assign w_an_on = (r_cnt != '0) && (r_cnt[c_CNT_W-1 -: PWM_BITS] <= r_act.bright);

    // Only the scanned digit's anode may be driven low.
    always_comb begin
        w_an_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_an_on && (r_idx == c_IDX_W'(i)))
                w_an_n[i] = 1'b0;
        end
    end

    // Slot counter, digit index and per-frame blink counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            if (w_cnt_last)
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            if (w_wrap)
                r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Double buffer: load fills pending; the frame wrap promotes pending to active.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_act       <= '0;
            r_act.blank <= '1;
            r_pend      <= '0;
            r_upd       <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_tick <= w_wrap && r_upd;
            if (w_wrap && r_upd)
                r_act <= r_pend;
            if (disp.load) begin
                r_pend <= w_in;
                r_upd  <= 1'b1;
            end else if (w_wrap) begin
                r_upd  <= 1'b0;
            end
        end
    end

    // Register the pins so they change one clock after index/count/buffer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_seg_n <= '1;
            r_dp_n  <= 1'b1;
            r_an_n  <= '1;
        end else begin
            r_seg_n <= w_off ? 7'h7F : ~w_pat;
            r_dp_n  <= w_off || !w_dpv;
            r_an_n  <= w_an_n;
        end
    end

    assign disp.seg_n          = r_seg_n;
    assign disp.dp_n           = r_dp_n;
    assign disp.an_n           = r_an_n;
    assign disp.update_pending = r_upd;
    assign disp.frame_tick     = r_tick;
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_mux
//  Description : Self-checking bench for seg7_scan_mux. A cycle model pushes
//                expected pin values at each clock edge; they are popped and
//                compared on the following falling edge. Directed constant
//                checks anchor segment patterns and anode timing per phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux;
    localparam int ND = 4;
    localparam int RD = 16;
    localparam int PB = 2;
    localparam int BB = 2;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seg7_scan_mux_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) dif ();

    seg7_scan_mux #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .PWM_BITS   (PB),
        .BLINK_BITS (BB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .disp   (dif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [27:0] raw;
        logic [3:0]  rawm;
        logic [3:0]  blank;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic [1:0]  bright;
    } buf_t;

    typedef struct {
        logic [6:0] seg_n;
        logic       dp_n;
        logic [3:0] an_n;
        logic       up;
        logic       tick;
        int         cnt;
        int         idx;
        int         blink;
        int         frame;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_cnt = 0, m_idx = 0, m_blink = 0, m_frame = 0;
    buf_t m_act, m_pend;
    logic m_upd = 1'b0;

    logic       dir_en = 1'b0;
    logic       dir_blink = 1'b0;
    int         dir_frame = 0;
    int         dir_last_on = 15;
    logic [6:0] dir_seg [4];

    // Single comparison point: counts every check, reports mismatches.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [3:0] onehot_n(input int i);
        logic [3:0] v;
        v = 4'hF;
        v[i] = 1'b0;
        return v;
    endfunction

    function automatic logic m_wrap();
        return (m_cnt == RD - 1) && (m_idx == ND - 1);
    endfunction

    function automatic buf_t cur_inputs();
        buf_t b;
        b.data   = dif.digit_data;
        b.raw    = dif.raw_seg;
        b.rawm   = dif.raw_mode;
        b.blank  = dif.blank;
        b.dp     = dif.dp;
        b.blink  = dif.blink;
        b.bright = dif.brightness;
        return b;
    endfunction

    // Expected pins after the coming edge, from the model state before it.
    function automatic exp_t predict();
        exp_t e;
        logic [3:0] lz;
        logic       seen;
        logic       off, on;
        logic [3:0] nib;
        lz   = 4'b0;
        seen = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
        for (int i = 0; i < ND; i++) begin
            nib = m_act.data[4*i +: 4];
            if (m_act.rawm[i] || (!m_act.blank[i] && nib != 4'd0)) seen = 1'b1;
            if (!seen && !m_act.rawm[i] && nib == 4'd0 && i != ND - 1) lz[i] = 1'b1;
        end
`endif
        nib = m_act.data[4*m_idx +: 4];
        off = m_act.blank[m_idx] || (m_act.blink[m_idx] && m_blink >= (1 << (BB - 1))) || lz[m_idx];
        on  = (m_cnt != 0) && ((m_cnt / (RD >> PB)) <= int'(m_act.bright));
        e.seg_n = off ? 7'h7F : ~(m_act.rawm[m_idx] ? m_act.raw[7*m_idx +: 7] : HEX_TAB[nib]);
        e.dp_n  = off ? 1'b1 : ~m_act.dp[m_idx];
        e.an_n  = on ? onehot_n(m_idx) : 4'hF;
        e.tick  = m_wrap() && m_upd;
        e.up    = dif.load ? 1'b1 : (m_wrap() ? 1'b0 : m_upd);
        e.cnt   = m_cnt;
        e.idx   = m_idx;
        e.blink = m_blink;
        e.frame = m_frame;
        return e;
    endfunction

    // Model step and scoreboard push on every active edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            sb.push_back('{7'h7F, 1'b1, 4'hF, 1'b0, 1'b0, -1, -1, 0, m_frame});
            m_cnt   <= 0;
            m_idx   <= 0;
            m_blink <= 0;
            m_act   <= '{data: 16'h0, raw: 28'h0, rawm: 4'h0, blank: 4'hF, dp: 4'h0, blink: 4'h0, bright: 2'd0};
            m_pend  <= '0;
            m_upd   <= 1'b0;
        end else begin
            sb.push_back(predict());
            m_cnt <= (m_cnt == RD - 1) ? 0 : m_cnt + 1;
            if (m_cnt == RD - 1) m_idx <= (m_idx == ND - 1) ? 0 : m_idx + 1;
            if (m_wrap()) begin
                m_blink <= (m_blink + 1) % (1 << BB);
                m_frame <= m_frame + 1;
                if (m_upd) m_act <= m_pend;
            end
            if (dif.load) begin
                m_pend <= cur_inputs();
                m_upd  <= 1'b1;
            end else if (m_wrap()) begin
                m_upd  <= 1'b0;
            end
        end
    end

    task automatic score(input exp_t e);
        chk("seg_n", dif.seg_n, e.seg_n);
        chk("dp_n", dif.dp_n, e.dp_n);
        chk("an_n", dif.an_n, e.an_n);
        chk("update_pending", dif.update_pending, e.up);
        chk("frame_tick", dif.frame_tick, e.tick);
        if (dir_en && e.cnt >= 0 && e.frame >= dir_frame) begin
            if (e.cnt == 5)
                chk("dir_seg", dif.seg_n,
                    (dir_blink && e.idx == 2) ? ((e.blink >= 2) ? 7'h7F : 7'h00) : dir_seg[e.idx]);
            if (e.cnt == 0) chk("dir_an_dead", dif.an_n, 4'hF);
            if (e.cnt == 1 || e.cnt == dir_last_on) chk("dir_an_on", dif.an_n, onehot_n(e.idx));
            if (e.cnt == dir_last_on + 1) chk("dir_an_off", dif.an_n, 4'hF);
        end
    endtask

    // Pop and compare away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) score(sb.pop_front());
    end

    task automatic drive(input logic [15:0] data, input logic [27:0] raw, input logic [3:0] rawm,
                         input logic [3:0] blank, input logic [3:0] dp, input logic [3:0] blink,
                         input logic [1:0] bright);
        dif.digit_data = data;
        dif.raw_seg    = raw;
        dif.raw_mode   = rawm;
        dif.blank      = blank;
        dif.dp         = dp;
        dif.blink      = blink;
        dif.brightness = bright;
        dif.load       = 1'b1;
        @(negedge clk);
        dif.load       = 1'b0;
    endtask

    // Returns on the falling edge just after a frame wrap.
    task automatic wait_wrap();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_cnt == 0 && m_idx == 0) return;
        end
        chk("wrap_timeout", 32'd0, 32'd1);
    endtask

    task automatic arm_dir(input int last_on);
        dir_last_on = last_on;
        dir_frame   = m_frame;
        dir_en      = 1'b1;
    endtask

    task automatic check_reset_pins(input string tag);
        chk({tag, "_an"}, dif.an_n, 4'hF);
        chk({tag, "_seg"}, dif.seg_n, 7'h7F);
        chk({tag, "_dp"}, dif.dp_n, 1'b1);
        chk({tag, "_up"}, dif.update_pending, 1'b0);
        chk({tag, "_tick"}, dif.frame_tick, 1'b0);
    endtask

    initial begin
        dif.digit_data = '0;
        dif.raw_seg    = '0;
        dif.raw_mode   = '0;
        dif.blank      = '0;
        dif.dp         = '0;
        dif.blink      = '0;
        dif.brightness = '0;
        dif.load       = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (21) @(negedge clk);

        // Mid-scan reset, then blank scan with reset brightness.
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_pins("reset");
        reset_n = 1'b1;
        dir_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        arm_dir(3);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Hex display, full brightness: digit0=1 ... digit3=4.
        drive(16'h4321, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        chk("pending_set", dif.update_pending, 1'b1);
        wait_wrap();
        chk("tick_basic", dif.frame_tick, 1'b1);
        chk("pending_clr", dif.update_pending, 1'b0);
        dir_seg = '{7'h4F, 7'h12, 7'h06, 7'h4C};
        arm_dir(15);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Minimum brightness.
        drive(16'h4321, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
        wait_wrap();
        arm_dir(3);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Two loads in one frame: the last one wins.
        drive(16'h1111, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        repeat (5) @(negedge clk);
        drive(16'h2222, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        wait_wrap();
        dir_seg = '{7'h12, 7'h12, 7'h12, 7'h12};
        arm_dir(15);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Load sampled on the wrap edge waits a whole frame.
        for (int k = 0; k < 200; k++) begin
            if (m_cnt == RD - 1 && m_idx == ND - 1) break;
            @(negedge clk);
        end
        drive(16'h5555, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        chk("wrapload_up", dif.update_pending, 1'b1);
        chk("wrapload_tick", dif.frame_tick, 1'b0);
        repeat (63) @(negedge clk);
        chk("wrapload_hold", dif.update_pending, 1'b1);
        @(negedge clk);
        chk("wrapload_apply_up", dif.update_pending, 1'b0);
        chk("wrapload_apply_tick", dif.frame_tick, 1'b1);
        dir_seg = '{7'h24, 7'h24, 7'h24, 7'h24};
        arm_dir(15);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Blink on digit 2.
        drive(16'h8888, 28'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 2'd3);
        wait_wrap();
        dir_seg   = '{7'h00, 7'h00, 7'h00, 7'h00};
        dir_blink = 1'b1;
        arm_dir(15);
        repeat (5 * 64) @(negedge clk);
        dir_en    = 1'b0;
        dir_blink = 1'b0;

        // Leading zeros: digit2=5, others 0.
        drive(16'h0500, 28'h0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd3);
        wait_wrap();
`ifdef LEADING_ZERO_SUPPRESS_EN
        dir_seg = '{7'h7F, 7'h7F, 7'h24, 7'h01};
`else
        dir_seg = '{7'h01, 7'h01, 7'h24, 7'h01};
`endif
        arm_dir(15);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Raw pattern on digit 1, decimal point on digit 3.
        drive(16'h0000, 28'h0001500, 4'b0010, 4'h0, 4'b1000, 4'h0, 2'd3);
        wait_wrap();
`ifdef LEADING_ZERO_SUPPRESS_EN
        dir_seg = '{7'h7F, 7'h55, 7'h01, 7'h01};
`else
        dir_seg = '{7'h01, 7'h55, 7'h01, 7'h01};
`endif
        arm_dir(15);
        repeat (64) @(negedge clk);
        dir_en = 1'b0;

        // Reset while displaying.
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_pins("reset_midop");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
